// File: rtl/comb_lock_pkg.sv
// Shared types and helpers for the combination lock and its display path.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY    = 3'd0,
    CHECK    = 3'd1,
    UNLOCKED = 3'd2,
    PROGRAM  = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}; index = displayed digit.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [7:0] thermo(input logic [3:0] n);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) t[i] = (i < int'(n));
    return t;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle countdown tick.
module tick_prescaler #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the first tick is consumed exactly DIV edges after restart.
  assign tick = !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/comb_lock_param.sv
// Multi-digit combination lock with unlock window, lockout and reprogramming.
module comb_lock_param
  import comb_lock_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 1,
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE = 16'h1234,
  parameter int UNLOCK_TICKS  = 10,
  parameter int MAX_FAIL      = 3,
  parameter int LOCKOUT_TICKS = 30
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [DIGIT_W-1:0]    digit_in,
  input  logic                  digit_valid,
  input  logic                  clear,
  input  logic                  prog_req,
  output logic [NUM_DIGITS-1:0] progress,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic [3:0]            fail_cnt,
  output logic [7:0]            ticks_left,
  output logic                  err_pulse,
  output logic                  prog_done
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W  = $clog2(NUM_DIGITS + 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CODE_W-1:0]   entry_buf, shadow_buf, code_reg, code_n;
  logic [CODE_W-1:0]   entry_wr, shadow_wr;
  logic [3:0]          fail_n, fail_inc;
  logic [7:0]          ticks_n;
  logic                err_n, done_n, restart, tick, last_digit;
  int                  slot;

  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick)
  );

  // Digit 0 lands in the most-significant field.
  always_comb begin
    slot       = (int'(idx) < NUM_DIGITS) ? (NUM_DIGITS - 1 - int'(idx)) : 0;
    last_digit = (int'(idx) == NUM_DIGITS - 1);
    entry_wr   = entry_buf;
    entry_wr[slot*DIGIT_W +: DIGIT_W] = digit_in;
    shadow_wr  = shadow_buf;
    shadow_wr[slot*DIGIT_W +: DIGIT_W] = digit_in;
    fail_inc   = (fail_cnt == 4'd15) ? 4'd15 : fail_cnt + 4'd1;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    code_n  = code_reg;
    fail_n  = fail_cnt;
    ticks_n = ticks_left;
    err_n   = 1'b0;
    done_n  = 1'b0;
    restart = 1'b0;
    case (state)
      ENTRY: begin
        if (clear) begin
          idx_n = '0;
        end else if (digit_valid) begin
          idx_n = idx + 1'b1;
          if (last_digit) state_n = CHECK;
        end
      end
      CHECK: begin
        idx_n = '0;
        if (entry_buf == code_reg) begin
          fail_n  = 4'd0;
          ticks_n = 8'(UNLOCK_TICKS);
          state_n = UNLOCKED;
          restart = 1'b1;
        end else begin
          err_n  = 1'b1;
          fail_n = fail_inc;
          if (fail_inc == 4'(MAX_FAIL)) begin
            ticks_n = 8'(LOCKOUT_TICKS);
            state_n = LOCKOUT;
            restart = 1'b1;
          end else begin
            state_n = ENTRY;
          end
        end
      end
      UNLOCKED: begin
        if (clear) begin
          idx_n   = '0;
          ticks_n = 8'd0;
          state_n = ENTRY;
        end else if (prog_req) begin
          idx_n   = '0;
          state_n = PROGRAM;
        end else if (tick) begin
          if (ticks_left == 8'd1) begin
            idx_n   = '0;
            ticks_n = 8'd0;
            state_n = ENTRY;
          end else begin
            ticks_n = ticks_left - 8'd1;
          end
        end
      end
      PROGRAM: begin
        if (clear) begin
          idx_n   = '0;
          ticks_n = 8'd0;
          state_n = ENTRY;
        end else if (digit_valid) begin
          if (last_digit) begin
            code_n  = shadow_wr;
            done_n  = 1'b1;
            idx_n   = '0;
            ticks_n = 8'd0;
            state_n = ENTRY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (ticks_left == 8'd1) begin
            fail_n  = 4'd0;
            ticks_n = 8'd0;
            idx_n   = '0;
            state_n = ENTRY;
          end else begin
            ticks_n = ticks_left - 8'd1;
          end
        end
      end
      default: begin
        idx_n   = '0;
        state_n = ENTRY;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ENTRY;
      idx        <= '0;
      code_reg   <= RESET_CODE;
      fail_cnt   <= 4'd0;
      ticks_left <= 8'd0;
      err_pulse  <= 1'b0;
      prog_done  <= 1'b0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      code_reg   <= code_n;
      fail_cnt   <= fail_n;
      ticks_left <= ticks_n;
      err_pulse  <= err_n;
      prog_done  <= done_n;
      unlocked   <= (state_n == UNLOCKED) || (state_n == PROGRAM);
      locked_out <= (state_n == LOCKOUT);
    end
  end

  // Digit buffers carry no control meaning; idx decides which slots are valid.
  always_ff @(posedge CLOCK_50) begin
    if (state == ENTRY && digit_valid && !clear) entry_buf <= entry_wr;
    if (state == PROGRAM && digit_valid && !clear) shadow_buf <= shadow_wr;
  end

  always_comb begin
    case (state)
      UNLOCKED: progress = '1;
      LOCKOUT:  progress = '0;
      default:  progress = NUM_DIGITS'(thermo(4'(idx)));
    endcase
  end

endmodule

// File: doc/comb_lock_param.md
Name: comb_lock_param

Overview:
- Parametrised successor to the board-level combination lock.
- Accepts a code of NUM_DIGITS digits, entered one digit at a time through a strobed digit port, and compares the whole code only after the last digit.
- Drives: progress LEDs, a timed unlock window, failed-attempt lockout with countdown, and in-field reprogramming of the code while unlocked.
- Sits between debounced switch/key inputs and the LED / 7-segment outputs of the top level.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, countdown tick rate; CLK_HZ/TICK_HZ must be an integer of at least 2.
- NUM_DIGITS, 4, digits per code (2..8).
- DIGIT_W, 4, bits per digit.
- RESET_CODE, 16'h1234, code loaded at reset; width NUM_DIGITS*DIGIT_W; digit 0 = most-significant field.
- UNLOCK_TICKS, 10, length of the unlock window in ticks (1..255).
- MAX_FAIL, 3, consecutive failures that trigger lockout (1..15).
- LOCKOUT_TICKS, 30, lockout duration in ticks (1..255).

Ports:
- CLOCK_50, in, 1, system clock.
- reset, in, 1, asynchronous, active-high reset.
- digit_in, in, DIGIT_W, digit value; sampled only when digit_valid=1.
- digit_valid, in, 1, single-cycle strobe, synchronous and already debounced.
- clear, in, 1, abandons the current entry.
- prog_req, in, 1, requests code reprogramming; honoured only in UNLOCKED.
- progress, out, NUM_DIGITS, thermometer count of digits accepted in the current entry.
- unlocked, out, 1, high in UNLOCKED and PROGRAM.
- locked_out, out, 1, high in LOCKOUT.
- fail_cnt, out, 4, consecutive failure count.
- ticks_left, out, 8, countdown value for the 7-segment display; 0 when no timer is running.
- err_pulse, out, 1, one-cycle pulse on a wrong code.
- prog_done, out, 1, one-cycle pulse when a new code is stored.

Behaviour:
- Reset (asynchronous, active-high): state=ENTRY, idx=0, code_reg=RESET_CODE, fail_cnt=0, ticks_left=0, all outputs low. Reset is honoured in any state, including mid-entry, mid-countdown and mid-program.
- Tick generator: counts CLOCK_50 cycles and emits a one-cycle tick every CLK_HZ/TICK_HZ cycles. The prescaler restarts at 0 on every entry to UNLOCKED or LOCKOUT, so the first tick arrives exactly one full period after entry.
- ENTRY:
  - On digit_valid, store digit_in into buffer slot idx and increment idx; progress shows idx ones, LSB first.
  - When the NUM_DIGITS-th digit is accepted, go to CHECK on the next cycle.
  - clear: idx=0, buffer discarded, fail_cnt unchanged.
  - digit_valid and clear in the same cycle: clear wins and the digit is dropped.
- CHECK (exactly 1 cycle), full-width compare of buffer against code_reg:
  - Match: fail_cnt=0, ticks_left=UNLOCK_TICKS, go to UNLOCKED.
  - Mismatch: err_pulse=1, fail_cnt+1, idx=0. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT with ticks_left=LOCKOUT_TICKS; otherwise return to ENTRY.
  - A mismatch never indicates which digit was wrong.
  - digit_valid arriving during CHECK is ignored.
- UNLOCKED:
  - progress is all ones.
  - Each tick decrements ticks_left. On the tick where ticks_left==1: ticks_left=0, idx=0, go to ENTRY.
  - prog_req=1: go to PROGRAM with idx=0. The timer freezes at its current value.
  - clear: relock immediately (ENTRY, ticks_left=0).
  - digit_valid is ignored.
- PROGRAM:
  - digit_valid fills a shadow buffer; progress shows the fill count.
  - After the NUM_DIGITS-th digit: code_reg=shadow, prog_done=1, idx=0, ticks_left=0, go to ENTRY.
  - clear: abort; code_reg unchanged, go to ENTRY.
  - No timeout in PROGRAM.
- LOCKOUT:
  - digit_valid, clear and prog_req are all ignored.
  - Each tick decrements ticks_left. On the tick where ticks_left==1: fail_cnt=0, ticks_left=0, go to ENTRY.
- fail_cnt saturates at 15. It clears only on a match, on lockout expiry, or on reset.
- Illegal state encoding: recover to ENTRY with idx=0.
- All outputs are registered except progress, which is decoded from idx and state.

Decomposition:
- Shared package comb_lock_pkg holds:
  - the state enumeration (ENTRY, CHECK, UNLOCKED, PROGRAM, LOCKOUT);
  - a thermometer-decode function;
  - the 7-segment digit constants, shared with the existing 7-segment decoder.
- One sub-module: tick_prescaler, parameters CLK_HZ and TICK_HZ; inputs CLOCK_50, reset, restart; output tick.
- BCD/7-segment display of ticks_left is done outside this block.

Test Plan:
Use CLK_HZ=10, TICK_HZ=1, NUM_DIGITS=4, RESET_CODE=16'h1234, UNLOCK_TICKS=3, MAX_FAIL=2, LOCKOUT_TICKS=4 for all scenarios.
1. Correct entry: strobe 1,2,3,4 → progress steps 0001, 0011, 0111, 1111; unlocked=1 two cycles after the 4th strobe; ticks_left reads 3, 2, 1 at 10-cycle spacing, then 0 with unlocked=0 at cycle 30 after entry.
2. Two wrong codes (1,2,3,5 twice): err_pulse after each; fail_cnt 1 then 2; locked_out=1 with ticks_left=4. Strobing 1,2,3,4 during lockout has no effect. Lockout releases after 40 cycles with fail_cnt=0; the correct code then unlocks.
3. Reprogram: unlock, assert prog_req, strobe 9,8,7,6 → prog_done pulse; now 1,2,3,4 gives err_pulse and 9,8,7,6 unlocks.
4. Clear mid-entry: strobe 1,2 then clear (same cycle as a 3rd strobe) → progress=0000, fail_cnt unchanged; a fresh 1,2,3,4 unlocks.
5. Reset mid-UNLOCKED, after a reprogram to 9876: assert reset asynchronously → outputs drop immediately, without a clock edge; after release, code 1,2,3,4 unlocks (RESET_CODE restored).
6. Single wrong code then correct code: fail_cnt 1→0, no lockout; one wrong code afterwards gives fail_cnt=1, not 2.
